// File: rtl/cavlc_bit_packer_pkg.sv
// cavlc_bit_packer_pkg: constants, state encoding and length helper for the CAVLC bit packer.
package cavlc_bit_packer_pkg;
    localparam int WORD_W = 16;
    localparam int ACC_W = 32;
    typedef enum logic [1:0] {PK_RUN, PK_FLUSH, PK_DONE} pk_state_e;
    // Lengths above 16 are treated as 16.
    function automatic logic [4:0] eff_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction
endpackage

// File: rtl/cavlc_bit_packer_if.sv
// cavlc_bit_packer_if: codeword input and packed-word output handshake bundle.
interface cavlc_bit_packer_if;
    import cavlc_bit_packer_pkg::*;
    logic in_valid;
    logic [15:0] in_code;
    logic [4:0] in_len;
    logic in_ready;
    logic flush;
    logic [0:WORD_W-1] out_word;
    logic out_valid;
    logic out_ready;
    logic flush_done;
    logic [15:0] bit_count;
    modport master(
        output in_valid, in_code, in_len, flush, out_ready,
        input in_ready, out_word, out_valid, flush_done, bit_count
    );
    modport slave(
        input in_valid, in_code, in_len, flush, out_ready,
        output in_ready, out_word, out_valid, flush_done, bit_count
    );
endinterface

// File: rtl/cavlc_bit_packer_align.sv
// cavlc_bit_align: places a right-aligned codeword at stream offset off within a 32-bit field.
module cavlc_bit_align
    import cavlc_bit_packer_pkg::*;
(
    input  logic [15:0]      code,
    input  logic [4:0]       len,
    input  logic [4:0]       off,
    output logic [ACC_W-1:0] field
);
    logic [15:0] mask;
    logic [5:0] sh;
    // Stream position p lives at field bit ACC_W-1-p; the codeword's last bit lands at 32-off-len.
    always_comb begin
        mask = len[4] ? 16'hFFFF : (16'd1 << len[3:0]) - 16'd1;
        sh = 6'd32 - {1'b0, off} - {1'b0, len};
        field = {16'b0, code & mask} << sh;
    end
endmodule

// File: rtl/cavlc_bit_packer.sv
// cavlc_bit_packer: packs 0..16-bit codewords MSB-first into 16-bit rbsp words, with zero-padded flush.
module cavlc_bit_packer
    import cavlc_bit_packer_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic ena,
    cavlc_bit_packer_if.slave bus
);
    pk_state_e state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, placed;
    logic [4:0] fill_q, fill_d, fill_b, len_eff;
    logic [0:WORD_W-1] out_word_q, out_word_d;
    logic out_valid_q, out_valid_d, flush_done_q, flush_done_d;
    logic [15:0] bit_count_q, bit_count_d;
    logic slot_free, drain, pad, in_ready, accept;

    cavlc_bit_align u_align (
        .code  (bus.in_code),
        .len   (len_eff),
        .off   (fill_b),
        .field (placed)
    );

    // Accumulator bit ACC_W-1 is the oldest stream bit; drains take the top WORD_W bits.
    always_comb begin
        len_eff = eff_len(bus.in_len);
        slot_free = !out_valid_q || bus.out_ready;
        drain = fill_q[4] && slot_free;
        pad = state_q == PK_FLUSH && fill_q != 5'd0 && !fill_q[4] && slot_free;
        in_ready = !rst && ena && state_q == PK_RUN && (!fill_q[4] || drain);
        accept = in_ready && bus.in_valid;
        fill_b = drain ? fill_q - 5'd16 : fill_q;
        acc_d = pad ? '0 : (drain ? acc_q << WORD_W : acc_q) | (accept ? placed : '0);
        fill_d = pad ? 5'd0 : fill_b + (accept ? len_eff : 5'd0);
        out_word_d = drain ? acc_q[ACC_W-1 -: WORD_W]
                   : pad ? acc_q[ACC_W-1 -: WORD_W] & ~(16'hFFFF >> fill_q[3:0])
                   : out_word_q;
        out_valid_d = drain || pad || (out_valid_q && !bus.out_ready);
        state_d = state_q == PK_RUN ? (bus.flush && in_ready ? PK_FLUSH : PK_RUN)
                : state_q == PK_FLUSH ? (fill_q == 5'd0 && slot_free ? PK_DONE : PK_FLUSH)
                : PK_RUN;
        flush_done_d = state_d == PK_DONE;
        bit_count_d = flush_done_d ? '0 : bit_count_q + (accept ? {11'b0, len_eff} : 16'd0);
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= PK_RUN;
            acc_q <= '0;
            fill_q <= '0;
            out_word_q <= '0;
            out_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
            bit_count_q <= '0;
        end else if (ena) begin
            state_q <= state_d;
            acc_q <= acc_d;
            fill_q <= fill_d;
            out_word_q <= out_word_d;
            out_valid_q <= out_valid_d;
            flush_done_q <= flush_done_d;
            bit_count_q <= bit_count_d;
        end

    assign bus.in_ready = in_ready;
    assign bus.out_word = out_word_q;
    assign bus.out_valid = out_valid_q;
    assign bus.flush_done = flush_done_q;
    assign bus.bit_count = bit_count_q;
endmodule
